// File: rtl/rom_seq_pkg.sv
// Shared definitions for the program-ROM sequencer: opcode values, FSM state
// encoding and instruction field helpers. The assembler and bench reuse this.
package rom_seq_pkg;

  localparam int OPC_W  = 8;
  localparam int OPND_W = 8;

  // Opcode byte values (instruction bits [7:0])
  localparam logic [OPC_W-1:0] OP_HALT  = 8'h00;
  localparam logic [OPC_W-1:0] OP_DELAY = 8'h10;
  localparam logic [OPC_W-1:0] OP_EMIT  = 8'h20;
  localparam logic [OPC_W-1:0] OP_JUMP  = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EMIT  = 3'd2,
    S_DELAY = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Opcode field OPC = [7:0]
  function automatic logic [OPC_W-1:0] get_opc(input logic [15:0] word);
    return word[7:0];
  endfunction

  // Operand field OPND = [15:8]
  function automatic logic [OPND_W-1:0] get_opnd(input logic [15:0] word);
    return word[15:8];
  endfunction

endpackage

// File: rtl/rom_seq_delay_cnt.sv
// Down-counter behind the DELAY instruction. Loaded with the operand when a
// non-zero DELAY is decoded, decremented once per DELAY cycle; done flags the
// last DELAY cycle so an operand of N yields exactly N cycles.
module rom_seq_delay_cnt
  import rom_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dec,
  input  logic [OPND_W-1:0] operand,
  output logic              done
);

  logic [OPND_W-1:0] cnt_q;
  logic [OPND_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down while in DELAY, floor at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = operand;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - OPND_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == OPND_W'(1));

endmodule

// File: rtl/rom_sequencer.sv
// Program-ROM sequencer: drives the ROM address from the program counter,
// decodes each fetched word in the FETCH cycle (no instruction register) and
// executes EMIT / JUMP / DELAY / HALT. EMIT operands leave on a valid/ready
// port that holds its data until the consumer takes it.
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  addrRd,
  input  logic [INSTR_W-1:0] dataRd,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic [OPC_W-1:0]  opc;
  logic [OPND_W-1:0] opnd;
  logic              dly_load;
  logic              dly_dec;
  logic              dly_done;

  assign opc  = get_opc(dataRd[15:0]);
  assign opnd = get_opnd(dataRd[15:0]);

  rom_seq_delay_cnt u_delay_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dly_load),
    .dec     (dly_dec),
    .operand (opnd),
    .done    (dly_done)
  );

  assign dly_dec = (state_q == S_DELAY);

  // Next-state and datapath decode; FETCH acts on the live ROM word
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    dly_load    = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        // start is only honoured when not executing
        if (start) begin
          pc_d    = START_ADDR;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        unique case (opc)
          OP_EMIT: begin
            out_data_d  = opnd;
            out_valid_d = 1'b1;
            state_d     = S_EMIT;
          end
          OP_JUMP: begin
            pc_d = ADDR_W'(opnd);
          end
          OP_DELAY: begin
            // A zero delay degenerates into a one-cycle NOP
            if (opnd == '0) begin
              pc_d = pc_q + ADDR_W'(1);
            end else begin
              dly_load = 1'b1;
              state_d  = S_DELAY;
            end
          end
          OP_HALT: begin
            // pc keeps pointing at the HALT word
            state_d = S_HALT;
          end
          default: begin
            // Undefined opcode: flag it and skip over the word
            err_d = 1'b1;
            pc_d  = pc_q + ADDR_W'(1);
          end
        endcase
      end

      S_EMIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_q + ADDR_W'(1);
          state_d     = S_FETCH;
        end
      end

      S_DELAY: begin
        if (dly_done) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_EMIT) || (state_d == S_DELAY);
    halted_d = (state_d == S_HALT);
  end

  // FSM, program counter and registered status/output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= START_ADDR;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign addrRd    = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule
